// File: rtl/s2p_core_if.sv
// Serial-in / parallel-out bundle for s2p_core: serial enable and bit in, word strobe and word out.
// The master side is the serial source and word consumer; the slave side is the converter itself.
interface s2p_core_if #(
  parameter int WIDTH = 8
);
  logic             wra_n;
  logic             da;
  logic             wrb;
  logic [WIDTH-1:0] db;

  modport master (
    output wra_n,
    output da,
    input  wrb,
    input  db
  );

  modport slave (
    input  wra_n,
    input  da,
    output wrb,
    output db
  );
endinterface

// File: rtl/s2p_core.sv
// s2p_core: collects WIDTH serial bits from da while wra_n is low and emits the word on db with a one-cycle wrb.
// Optional feature macro S2P_PARTIAL_FLUSH_EN: an aborted partial word is flushed, aligned as in a full word.
module s2p_core #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic        clka,
  input logic        rst,
  s2p_core_if.slave  bus
);
  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;

  // MSB-first fills from the bottom and shifts up; LSB-first fills from the top and shifts down.
  always_comb begin
    shifted = sreg;
    if (MSB_FIRST) shifted = {sreg[WIDTH-2:0], bus.da};
    else           shifted = {bus.da, sreg[WIDTH-1:1]};
  end

`ifdef S2P_PARTIAL_FLUSH_EN
  logic [CW-1:0]    gap;
  logic [WIDTH-1:0] partial;

  // cnt bits are packed at the filling end; moving them by the missing-bit count aligns them.
  always_comb begin
    gap     = CW'(WIDTH) - cnt;
    partial = MSB_FIRST ? (sreg << gap) : (sreg >> gap);
  end
`endif

  always_ff @(posedge clka) begin
    if (rst) begin
      cnt     <= '0;
      sreg    <= '0;
      bus.db  <= '0;
      bus.wrb <= 1'b0;
    end else begin
      bus.wrb <= 1'b0;
      if (!bus.wra_n) begin
        if (cnt == LAST) begin
          bus.db  <= shifted;
          bus.wrb <= 1'b1;
          cnt     <= '0;
          sreg    <= '0;
        end else begin
          sreg <= shifted;
          cnt  <= cnt + 1'b1;
        end
      end else if (cnt != '0) begin
`ifdef S2P_PARTIAL_FLUSH_EN
        bus.db  <= partial;
        bus.wrb <= 1'b1;
`endif
        cnt  <= '0;
        sreg <= '0;
      end
    end
  end
endmodule

// File: tb/tb_s2p_core.sv
// Bench for s2p_core: an MSB-first and an LSB-first instance share one stimulus stream and are
// checked every cycle against a bit-queue reference model, plus directed word-level expectations.
module tb_s2p_core;
  localparam int WIDTH = 8;

  logic clka = 1'b0;
  logic rst  = 1'b1;
  always #5 clka = ~clka;

  s2p_core_if #(.WIDTH(WIDTH)) bus_msb ();
  s2p_core_if #(.WIDTH(WIDTH)) bus_lsb ();

  s2p_core #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clka (clka),
    .rst  (rst),
    .bus  (bus_msb.slave)
  );

  s2p_core #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clka (clka),
    .rst  (rst),
    .bus  (bus_lsb.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulses = 0;
  int last_pulse = -1;
  int prev_pulse = -1;

  logic             bitq[$];
  logic [WIDTH-1:0] exp_db_msb = '0;
  logic [WIDTH-1:0] exp_db_lsb = '0;
  logic             exp_wrb    = 1'b0;

  task automatic check_output(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Place the queued bits by arrival order: i-th bit at WIDTH-1-i (MSB-first) or at i (LSB-first).
  task automatic model_emit();
    exp_db_msb = '0;
    exp_db_lsb = '0;
    foreach (bitq[i]) begin
      exp_db_msb[WIDTH-1-i] = bitq[i];
      exp_db_lsb[i]         = bitq[i];
    end
    exp_wrb = 1'b1;
    bitq.delete();
  endtask

  task automatic model_edge(input logic r, input logic w, input logic d);
    if (r) begin
      bitq.delete();
      exp_db_msb = '0;
      exp_db_lsb = '0;
      exp_wrb    = 1'b0;
    end else begin
      exp_wrb = 1'b0;
      if (!w) begin
        bitq.push_back(d);
        if (bitq.size() == WIDTH) model_emit();
      end else if (bitq.size() != 0) begin
`ifdef S2P_PARTIAL_FLUSH_EN
        model_emit();
`else
        bitq.delete();
`endif
      end
    end
  endtask

  // One clock edge: drive, let the edge happen, update the model, then compare both instances.
  task automatic apply_stimulus(input logic r, input logic w, input logic d);
    rst           = r;
    bus_msb.wra_n = w;
    bus_msb.da    = d;
    bus_lsb.wra_n = w;
    bus_lsb.da    = d;
    @(posedge clka);
    model_edge(r, w, d);
    #1;
    cyc++;
    check_output("db_msb", bus_msb.db, exp_db_msb);
    check_bit("wrb_msb", bus_msb.wrb, exp_wrb);
    check_output("db_lsb", bus_lsb.db, exp_db_lsb);
    check_bit("wrb_lsb", bus_lsb.wrb, exp_wrb);
    if (bus_msb.wrb === 1'b1) begin
      pulses++;
      prev_pulse = last_pulse;
      last_pulse = cyc;
    end
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] w, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, w[WIDTH-1-i]);
  endtask

  initial begin
    rst           = 1'b1;
    bus_msb.wra_n = 1'b0;
    bus_msb.da    = 1'b0;
    bus_lsb.wra_n = 1'b0;
    bus_lsb.da    = 1'b0;

    $display("[TB] reset held with da toggling");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, logic'(i[0]));
    check_output("reset_db", bus_msb.db, 8'h00);
    check_bit("reset_wrb", bus_msb.wrb, 1'b0);

    $display("[TB] single word");
    pulses = 0;
    send_bits(8'hB2, 7);
    check_int("no_early_strobe", pulses, 0);
    send_bits(8'h02 << 7, 1);
    check_output("single_msb", bus_msb.db, 8'hB2);
    check_output("single_lsb", bus_lsb.db, 8'h4D);
    check_bit("single_wrb", bus_msb.wrb, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    check_bit("single_wrb_drop", bus_msb.wrb, 1'b0);

    $display("[TB] back-to-back words");
    pulses = 0;
    send_bits(8'hB2, 8);
    check_output("b2b_first", bus_msb.db, 8'hB2);
    send_bits(8'h5A, 8);
    check_output("b2b_second", bus_msb.db, 8'h5A);
    check_int("b2b_pulses", pulses, 2);
    check_int("b2b_spacing", last_pulse - prev_pulse, 8);

    $display("[TB] abort mid-word");
    pulses = 0;
    send_bits(8'hE0, 3);
    apply_stimulus(1'b0, 1'b1, 1'b0);
`ifdef S2P_PARTIAL_FLUSH_EN
    check_output("abort_msb", bus_msb.db, 8'hE0);
    check_output("abort_lsb", bus_lsb.db, 8'h07);
    check_int("abort_pulses", pulses, 1);
`else
    check_output("abort_msb", bus_msb.db, 8'h5A);
    check_output("abort_lsb", bus_lsb.db, 8'h5A);
    check_int("abort_pulses", pulses, 0);
`endif
    apply_stimulus(1'b0, 1'b1, 1'b1);
    check_bit("abort_wrb_drop", bus_msb.wrb, 1'b0);

    $display("[TB] reset mid-word");
    send_bits(8'hFF, 5);
    pulses = 0;
    apply_stimulus(1'b1, 1'b0, 1'b1);
    send_bits(8'hC3, 8);
    check_int("rstmid_pulses", pulses, 1);
    check_output("rstmid_msb", bus_msb.db, 8'hC3);
    check_output("rstmid_lsb", bus_lsb.db, 8'hC3);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      logic r, w, d;
      r = ($urandom_range(0, 99) < 2);
      w = ($urandom_range(0, 99) < 15);
      d = logic'($urandom_range(0, 1));
      apply_stimulus(r, w, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
